// File: rtl/motor_pkg.sv
// Shared motor-path types and defaults: capture FSM states, tick constants,
// and the 10-bit motor-signal scale used by both the PWM generator and capture.
package motor_pkg;

  typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, LOW} pwmcap_state_t;

  localparam int CLK_PER_TICK_DEF  = 48;
  localparam int MIN_TICKS_DEF     = 1042;
  localparam int TIMEOUT_TICKS_DEF = 26042;
  localparam int MOTOR_SIG_W       = 10;
  localparam int MOTOR_SIG_MAX     = (1 << MOTOR_SIG_W) - 1;

  // 17-bit difference keeps the sign so pulses shorter than min_ticks clamp to 0.
  function automatic logic [MOTOR_SIG_W-1:0] pwm_scale(input logic [15:0] hi,
                                                       input logic [15:0] min_ticks);
    logic [16:0] diff;
    diff = {1'b0, hi} - {1'b0, min_ticks};
    if (diff[16])
      return '0;
    else if (diff > 17'(MOTOR_SIG_MAX))
      return '1;
    else
      return diff[MOTOR_SIG_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus edge register for a slow asynchronous level input;
// produces registered one-cycle rise/fall pulses aligned with the level output.
module pwm_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic primed,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1, s2, s3;
  logic [2:0] prime_sr;

  // Edges are masked until the chain has filled after reset, so a pin that is
  // already high at reset release never looks like a fresh rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      prime_sr <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      s1       <= din;
      s2       <= s1;
      s3       <= s2;
      prime_sr <= {prime_sr[1:0], 1'b1};
      rise     <= prime_sr[2] & s2 & ~s3;
      fall     <= prime_sr[2] & ~s2 & s3;
    end
  end

  assign primed = prime_sr[2];
  assign level  = s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures RC-style PWM high time and period in prescaled ticks and converts
// the high time to the 10-bit motor-signal scale, with a timeout-driven lost flag.
module pwm_capture
  import motor_pkg::*;
#(
  parameter int CLK_PER_TICK  = CLK_PER_TICK_DEF,
  parameter int MIN_TICKS     = MIN_TICKS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                   c50m,
  input  logic                   reset,
  input  logic                   PWMin,
  output logic [15:0]            HighTicks,
  output logic [15:0]            PeriodTicks,
  output logic [MOTOR_SIG_W-1:0] MotorSignalMeas,
  output logic                   SampleValid,
  output logic                   SignalLost,
  output pwmcap_state_t          state_dbg
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  logic          primed, level, rise, fall;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   hi_cnt, per_cnt, per_inc;
  logic          per_at_max, hi_at_max;
  pwmcap_state_t state, state_d;
  logic          clr_cnt, inc_hi, inc_per, complete, set_lost;

  pwm_sync_edge u_sync (
    .clk    (c50m),
    .reset  (reset),
    .din    (PWMin),
    .primed (primed),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign tick       = (presc == PW'(CLK_PER_TICK - 1));
  assign per_at_max = (per_cnt == 16'(TIMEOUT_TICKS));
  assign hi_at_max  = (hi_cnt == 16'(TIMEOUT_TICKS));
  // Period includes a tick landing on the closing rise, matching how a tick on
  // the falling edge still counts toward the high time.
  assign per_inc    = (tick && !per_at_max) ? per_cnt + 16'd1 : per_cnt;
  assign state_dbg  = state;

  always_ff @(posedge c50m) begin
    if (reset || rise)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  always_ff @(posedge c50m) begin
    if (reset)
      state <= ARM;
    else
      state <= state_d;
  end

  always_comb begin
    state_d  = state;
    clr_cnt  = 1'b0;
    inc_hi   = 1'b0;
    inc_per  = 1'b0;
    complete = 1'b0;
    set_lost = 1'b0;
    case (state)
      ARM: begin
        clr_cnt = 1'b1;
        if (primed && !level) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          clr_cnt = 1'b1;
          state_d = HIGH;
        end else begin
          inc_per  = tick;
          set_lost = per_at_max;
        end
      end
      HIGH: begin
        if (per_at_max) begin
          set_lost = 1'b1;
          state_d  = ARM;
        end else begin
          inc_hi  = tick;
          inc_per = tick;
          if (fall) state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          complete = 1'b1;
          clr_cnt  = 1'b1;
          state_d  = HIGH;
        end else if (per_at_max) begin
          set_lost = 1'b1;
          state_d  = ARM;
        end else begin
          inc_per = tick;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge c50m) begin
    if (reset) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else if (clr_cnt) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      if (inc_hi && !hi_at_max) hi_cnt <= hi_cnt + 16'd1;
      if (inc_per && !per_at_max) per_cnt <= per_cnt + 16'd1;
    end
  end

  // SampleValid is a pure one-cycle strobe with no ready: the consumer must
  // capture HighTicks/PeriodTicks/MotorSignalMeas in the cycle it is high.
  always_ff @(posedge c50m) begin
    if (reset) begin
      HighTicks       <= '0;
      PeriodTicks     <= '0;
      MotorSignalMeas <= '0;
      SampleValid     <= 1'b0;
      SignalLost      <= 1'b1;
    end else begin
      SampleValid <= complete;
      if (complete) begin
        HighTicks       <= hi_cnt;
        PeriodTicks     <= per_inc;
        MotorSignalMeas <= pwm_scale(hi_cnt, 16'(MIN_TICKS));
        SignalLost      <= 1'b0;
      end else if (set_lost) begin
        SignalLost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with shortened tick constants: table of PWM periods
// with hand-derived expectations, plus timeout, reset and glitch sequences.
module tb_pwm_capture;
  import motor_pkg::*;

  localparam int CPT  = 3;
  localparam int MINT = 50;
  localparam int TOT  = 1500;

  logic                   c50m = 1'b0;
  logic                   reset = 1'b1;
  logic                   PWMin = 1'b0;
  logic [15:0]            HighTicks, PeriodTicks;
  logic [MOTOR_SIG_W-1:0] MotorSignalMeas;
  logic                   SampleValid, SignalLost;
  pwmcap_state_t          state_dbg;

  pwm_capture #(
    .CLK_PER_TICK  (CPT),
    .MIN_TICKS     (MINT),
    .TIMEOUT_TICKS (TOT)
  ) dut (
    .c50m            (c50m),
    .reset           (reset),
    .PWMin           (PWMin),
    .HighTicks       (HighTicks),
    .PeriodTicks     (PeriodTicks),
    .MotorSignalMeas (MotorSignalMeas),
    .SampleValid     (SampleValid),
    .SignalLost      (SignalLost),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #10 c50m = ~c50m;

  initial begin
    repeat (95000) @(posedge c50m);
    $display("FAIL watchdog: run exceeded 95000 cycles");
    $fatal(1, "watchdog");
  end

  // scoreboard
  typedef struct {
    int h;
    int p;
    int hi;
    int per;
    int msm;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_strobe = 0;
  int          n_pushed = 0;
  logic [41:0] exp_q[$];
  logic [41:0] pending;
  bit          pending_v = 1'b0;
  vec_t        tbl[10];

  function automatic logic [41:0] pk(input int hi, input int per, input int msm);
    return {16'(hi), 16'(per), 10'(msm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge c50m) begin
    if (!reset && SampleValid) begin
      n_strobe++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe hi=%0d expected none at %0t",
                 HighTicks, $time);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("high_ticks", 32'(HighTicks), 32'(e[41:26]));
        check("period_ticks", 32'(PeriodTicks), 32'(e[25:10]));
        check("motor_signal", 32'(MotorSignalMeas), 32'(e[9:0]));
        check("lost_on_strobe", 32'(SignalLost), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge c50m);
    #1;
  endtask

  task automatic rise_edge();
    if (pending_v) begin
      exp_q.push_back(pending);
      n_pushed++;
    end
    pending_v = 1'b0;
    PWMin = 1'b1;
  endtask

  task automatic drive_period(input int h, input int p, input logic [41:0] e);
    rise_edge();
    step(h);
    PWMin = 1'b0;
    step(p - h);
    pending   = e;
    pending_v = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1712, 3800, 570, 1266, 520};
    tbl[1] = '{149, 3001, 49, 1000, 0};
    tbl[2] = '{150, 3000, 50, 1000, 0};
    tbl[3] = '{153, 2999, 51, 999, 1};
    tbl[4] = '{3300, 4000, 1100, 1333, 1023};
    tbl[5] = '{3220, 4100, 1073, 1366, 1023};
    tbl[6] = '{3222, 4100, 1074, 1366, 1023};
    tbl[7] = '{3216, 4000, 1072, 1333, 1022};
    tbl[8] = '{2, 3500, 0, 1166, 0};
    tbl[9] = '{1, 3100, 0, 1033, 0};

    reset = 1'b1;
    PWMin = 1'b0;
    step(3);
    @(negedge c50m);
    check("rst_high_ticks", 32'(HighTicks), 32'd0);
    check("rst_period_ticks", 32'(PeriodTicks), 32'd0);
    check("rst_motor_signal", 32'(MotorSignalMeas), 32'd0);
    check("rst_valid", 32'(SampleValid), 32'd0);
    check("rst_lost", 32'(SignalLost), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(ARM));
    step(1);
    reset = 1'b0;
    step(10);
    check("armed_state", 32'(state_dbg), 32'(WAIT_RISE));

    for (int i = 0; i < 10; i++) begin
      drive_period(tbl[i].h, tbl[i].p, pk(tbl[i].hi, tbl[i].per, tbl[i].msm));
      if (i == 0) check("lost_before_first", 32'(SignalLost), 32'd1);
      if (i == 1) check("lost_after_first", 32'(SignalLost), 32'd0);
    end

    // stuck low after a valid period
    drive_period(1712, 3800, pk(570, 1266, 520));
    pending_v = 1'b0;
    step(TOT * CPT - 3800 - 20);
    check("low_lost_early", 32'(SignalLost), 32'd0);
    step(40);
    check("low_lost_set", 32'(SignalLost), 32'd1);
    check("low_state", 32'(state_dbg), 32'(WAIT_RISE));
    check("low_hold_hi", 32'(HighTicks), 32'd0);
    check("low_hold_per", 32'(PeriodTicks), 32'd1033);

    // recovery then stuck high
    drive_period(1712, 3800, pk(570, 1266, 520));
    check("recover_lost_still", 32'(SignalLost), 32'd1);
    rise_edge();
    step(TOT * CPT - 20);
    check("high_lost_early", 32'(SignalLost), 32'd0);
    step(40);
    check("high_lost_set", 32'(SignalLost), 32'd1);
    check("high_state", 32'(state_dbg), 32'(ARM));
    check("high_hold_msm", 32'(MotorSignalMeas), 32'd520);
    PWMin = 1'b0;
    step(10);
    check("high_rearm", 32'(state_dbg), 32'(WAIT_RISE));

    // reset mid-HIGH, released while the pin is still high
    drive_period(3300, 4000, pk(1100, 1333, 1023));
    rise_edge();
    step(500);
    reset = 1'b1;
    step(1);
    @(negedge c50m);
    check("midrst_high_ticks", 32'(HighTicks), 32'd0);
    check("midrst_period", 32'(PeriodTicks), 32'd0);
    check("midrst_motor", 32'(MotorSignalMeas), 32'd0);
    check("midrst_lost", 32'(SignalLost), 32'd1);
    check("midrst_state", 32'(state_dbg), 32'(ARM));
    step(1);
    reset = 1'b0;
    step(300);
    PWMin = 1'b0;
    step(1000);
    drive_period(1712, 3800, pk(570, 1266, 520));
    check("partial_lost_still", 32'(SignalLost), 32'd1);
    drive_period(153, 4000, pk(51, 1333, 1));
    check("partial_recovered", 32'(SignalLost), 32'd0);
    rise_edge();
    step(20);
    PWMin = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("strobe_count", 32'(n_strobe), 32'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
